// File: rtl/jtkonami_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtkonami_io_ctrl                                                  |
// | Brief    : Konami 6809-class main-CPU I/O block: bank regs, sound latch/IRQ, |
// |            watchdog, coin counters and input-port read mux.                  |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module jtkonami_io_ctrl #(
  parameter int BANKW    = 4,
  parameter int IRQ_LEN  = 8,
  parameter int WDOG_W   = 16,
  parameter int WDOG_EN  = 1,
  parameter int COIN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_cen,
  input  logic             io_cs,
  input  logic [4:0]       addr,
  input  logic             rnw,
  input  logic [7:0]       cpu_dout,
  input  logic [1:0]       start_button,
  input  logic [1:0]       coin_input,
  input  logic [5:0]       joystick1,
  input  logic [5:0]       joystick2,
  input  logic             service,
  input  logic [7:0]       dipsw_a,
  input  logic [7:0]       dipsw_b,
  input  logic [3:0]       dipsw_c,
  output logic [7:0]       io_dout,
  output logic [BANKW-1:0] bank,
  output logic             video_sel,
  output logic             prio_sel,
  output logic             bank_en,
  output logic [7:0]       video_bank,
  output logic [7:0]       snd_latch,
  output logic             snd_irq,
  input  logic             snd_ack,
  output logic [1:0]       coin_cnt,
  output logic             wdog_rst
);

  localparam int c_IRQ_W  = $clog2(IRQ_LEN + 1);
  localparam int c_COIN_W = $clog2(COIN_LEN + 1);
  localparam logic [c_IRQ_W-1:0]  c_IRQ_LOAD  = c_IRQ_W'(IRQ_LEN);
  localparam logic [c_IRQ_W-1:0]  c_IRQ_ONE   = c_IRQ_W'(1);
  localparam logic [c_COIN_W-1:0] c_COIN_LOAD = c_COIN_W'(COIN_LEN);
  localparam logic [c_COIN_W-1:0] c_COIN_ONE  = c_COIN_W'(1);

  logic       w_wr;
  logic [2:0] w_sel;
  logic       w_trig;
  logic       w_kick;
  logic       w_coin_wr;
  logic [7:0] w_rd_data;

  assign w_wr      = cpu_cen & io_cs & ~rnw;
  assign w_sel     = addr[4:2];
  assign w_coin_wr = w_wr && (w_sel == 3'd2);
  assign w_trig    = w_wr && (w_sel == 3'd6);
  assign w_kick    = w_wr && (w_sel == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      video_bank <= '0;
      video_sel  <= 1'b0;
      prio_sel   <= 1'b0;
      bank_en    <= 1'b0;
      bank       <= '0;
      snd_latch  <= '0;
    end else if (w_wr) begin
      case (w_sel)
        3'd3: video_bank <= cpu_dout;
        3'd4: begin
          video_sel <= cpu_dout[6];
          prio_sel  <= cpu_dout[5];
          bank_en   <= cpu_dout[4];
          bank      <= cpu_dout[BANKW-1:0];
        end
        3'd5: snd_latch <= cpu_dout;
        default: ;
      endcase
    end
  end

  // Read ports occupy A[4:3]==00, below the write-only register windows.
  always_comb begin
    w_rd_data = 8'hff;
    if (addr[4:3] == 2'b00) begin
      case (addr[2:0])
        3'd0: w_rd_data = {3'b111, start_button, service, coin_input};
        3'd1: w_rd_data = {2'b11, joystick1[5:4], joystick1[2], joystick1[3],
                           joystick1[0], joystick1[1]};
        3'd2: w_rd_data = {2'b11, joystick2[5:4], joystick2[2], joystick2[3],
                           joystick2[0], joystick2[1]};
        3'd4: w_rd_data = dipsw_a;
        3'd5: w_rd_data = dipsw_b;
        3'd6: w_rd_data = {4'hf, dipsw_c};
        default: w_rd_data = 8'hff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) io_dout <= 8'hff;
    else if (io_cs && rnw) io_dout <= w_rd_data;
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} irq_state_t;
  irq_state_t         r_irq_st, w_irq_st_nx;
  logic [c_IRQ_W-1:0] r_irq_cnt, w_irq_cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_st  <= ST_IDLE;
      r_irq_cnt <= '0;
    end else begin
      r_irq_st  <= w_irq_st_nx;
      r_irq_cnt <= w_irq_cnt_nx;
    end
  end

  // A trigger outranks a simultaneous acknowledge so no command is lost.
  always_comb begin
    w_irq_st_nx  = r_irq_st;
    w_irq_cnt_nx = r_irq_cnt;
    if (w_trig) begin
      w_irq_st_nx  = ST_ACTIVE;
      w_irq_cnt_nx = c_IRQ_LOAD;
    end else if (r_irq_st == ST_ACTIVE) begin
      if (snd_ack) begin
        w_irq_st_nx  = ST_IDLE;
        w_irq_cnt_nx = '0;
      end else if (cpu_cen) begin
        if (r_irq_cnt <= c_IRQ_ONE) begin
          w_irq_st_nx  = ST_IDLE;
          w_irq_cnt_nx = '0;
        end else begin
          w_irq_cnt_nx = r_irq_cnt - c_IRQ_ONE;
        end
      end
    end
  end

  assign snd_irq = (r_irq_st == ST_ACTIVE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_coin
    logic                r_req;
    logic [c_COIN_W-1:0] r_cnt;
    logic                w_rise;

    assign w_rise = w_coin_wr & cpu_dout[gi] & ~r_req;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_req <= 1'b0;
        r_cnt <= '0;
      end else if (cpu_cen) begin
        if (w_coin_wr) r_req <= cpu_dout[gi];
        if (w_rise) r_cnt <= c_COIN_LOAD;
        else if (r_cnt != '0) r_cnt <= r_cnt - c_COIN_ONE;
      end
    end

    assign coin_cnt[gi] = r_req | (r_cnt != '0);
  end

  if (WDOG_EN != 0) begin : g_wdog
    logic [WDOG_W-1:0] r_cnt;
    logic [WDOG_W-1:0] w_cnt_inc;
    logic              r_pulse;

    assign w_cnt_inc = r_cnt + WDOG_W'(1);

    // Reaching all-ones fires and wraps in the same tick: period is 2**W-1.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (cpu_cen) begin
          if (w_kick) begin
            r_cnt <= '0;
          end else if (&w_cnt_inc) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end
    end

    assign wdog_rst = r_pulse;
  end else begin : g_no_wdog
    assign wdog_rst = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtkonami_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jtkonami_io_ctrl                                               |
// | Brief    : Directed and randomized bench for jtkonami_io_ctrl.               |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jtkonami_io_ctrl;
  localparam int IRQ_LEN  = 8;
  localparam int COIN_LEN = 4;
  localparam int WDOG_W   = 4;
  localparam int c_WD_PER = (1 << WDOG_W) - 1;

  logic       clk = 1'b0;
  logic       rst, cpu_cen, io_cs, rnw, snd_ack, service;
  logic [4:0] addr;
  logic [7:0] cpu_dout, dipsw_a, dipsw_b;
  logic [1:0] start_button, coin_input;
  logic [5:0] joystick1, joystick2;
  logic [3:0] dipsw_c;
  logic [7:0] io_dout, video_bank, snd_latch;
  logic [3:0] bank;
  logic       video_sel, prio_sel, bank_en, snd_irq, wdog_rst;
  logic [1:0] coin_cnt;

  always #5 clk = ~clk;

  jtkonami_io_ctrl #(.BANKW(4), .IRQ_LEN(IRQ_LEN), .WDOG_W(WDOG_W), .WDOG_EN(1),
                     .COIN_LEN(COIN_LEN)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .io_cs(io_cs), .addr(addr), .rnw(rnw),
    .cpu_dout(cpu_dout), .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .service(service),
    .dipsw_a(dipsw_a), .dipsw_b(dipsw_b), .dipsw_c(dipsw_c), .io_dout(io_dout),
    .bank(bank), .video_sel(video_sel), .prio_sel(prio_sel), .bank_en(bank_en),
    .video_bank(video_bank), .snd_latch(snd_latch), .snd_irq(snd_irq),
    .snd_ack(snd_ack), .coin_cnt(coin_cnt), .wdog_rst(wdog_rst)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time-stamped events measured in cpu_cen ticks.
  int         m_ticks, m_irq_t0, m_wd_last;
  int         m_rise[2];
  bit         m_irq, m_wdog, m_vsel, m_psel, m_ben;
  bit   [1:0] m_req;
  logic [7:0] m_dout, m_vbank, m_latch;
  logic [3:0] m_bank;

  function automatic logic [7:0] exp_read(input logic [4:0] a);
    if (a[4:3] != 2'b00) return 8'hff;
    case (a[2:0])
      3'd0: return {3'b111, start_button, service, coin_input};
      3'd1: return {2'b11, joystick1[5], joystick1[4], joystick1[2], joystick1[3],
                    joystick1[0], joystick1[1]};
      3'd2: return {2'b11, joystick2[5], joystick2[4], joystick2[2], joystick2[3],
                    joystick2[0], joystick2[1]};
      3'd4: return dipsw_a;
      3'd5: return dipsw_b;
      3'd6: return {4'hf, dipsw_c};
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic [1:0] exp_coin();
    logic [1:0] c;
    for (int i = 0; i < 2; i++)
      c[i] = m_req[i] || ((m_ticks - m_rise[i]) < COIN_LEN);
    return c;
  endfunction

  function automatic logic [39:0] exp_all();
    return {m_dout, m_bank, m_vsel, m_psel, m_ben, m_vbank, m_latch, m_irq,
            exp_coin(), m_wdog};
  endfunction

  function automatic logic [39:0] dut_all();
    return {io_dout, bank, video_sel, prio_sel, bank_en, video_bank, snd_latch,
            snd_irq, coin_cnt, wdog_rst};
  endfunction

  task automatic model_reset();
    m_ticks = 0; m_irq_t0 = 0; m_wd_last = 0;
    m_rise[0] = -1000; m_rise[1] = -1000;
    m_irq = 0; m_wdog = 0; m_vsel = 0; m_psel = 0; m_ben = 0; m_req = '0;
    m_dout = 8'hff; m_vbank = '0; m_latch = '0; m_bank = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_cen = 1'b1; io_cs = 1'b0; rnw = 1'b1; snd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, let the edge pass, advance the model.
  task automatic step(input bit cen, input bit cs, input bit rd, input logic [4:0] a,
                      input logic [7:0] d, input bit ack);
    bit wr;
    cpu_cen = cen; io_cs = cs; rnw = rd; addr = a; cpu_dout = d; snd_ack = ack;
    @(posedge clk);
    #1;
    wr = cen & cs & ~rd;
    m_wdog = 0;
    if (cen) m_ticks++;
    if (cs && rd) m_dout = exp_read(a);
    if (wr && a[4:2] == 3'd3) m_vbank = d;
    if (wr && a[4:2] == 3'd4) begin
      m_vsel = d[6]; m_psel = d[5]; m_ben = d[4]; m_bank = d[3:0];
    end
    if (wr && a[4:2] == 3'd5) m_latch = d;
    if (wr && a[4:2] == 3'd6) begin
      m_irq = 1; m_irq_t0 = m_ticks;
    end else if (ack) begin
      m_irq = 0;
    end else if (m_irq && (m_ticks - m_irq_t0) >= IRQ_LEN) begin
      m_irq = 0;
    end
    if (wr && a[4:2] == 3'd2) begin
      for (int i = 0; i < 2; i++) begin
        if (d[i] && !m_req[i]) m_rise[i] = m_ticks;
        m_req[i] = d[i];
      end
    end
    if (cen) begin
      if (wr && a[4:2] == 3'd7) m_wd_last = m_ticks;
      else if ((m_ticks - m_wd_last) == c_WD_PER) begin
        m_wdog = 1; m_wd_last = m_ticks;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 5'h1f, 8'h00, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (io_dout !== 8'hff) begin
      errors++; $display("FAIL reset_io_dout got %h want ff", io_dout);
    end
    checks++;
    if ({bank, video_sel, prio_sel, bank_en, video_bank, snd_latch, snd_irq,
         coin_cnt, wdog_rst} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bank=%h vb=%h sl=%h irq=%b coin=%b wd=%b want all 0",
               bank, video_bank, snd_latch, snd_irq, coin_cnt, wdog_rst);
    end
  endtask

  task automatic test_bank();
    step(1, 1, 0, 5'h10, 8'h5b, 0);
    checks++;
    if ({bank, bank_en, prio_sel, video_sel} !== {4'hb, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bank_write got bank=%h en=%b prio=%b vsel=%b want b 1 0 1",
               bank, bank_en, prio_sel, video_sel);
    end
    step(1, 1, 0, 5'h0c, 8'ha7, 0);
    checks++;
    if (video_bank !== 8'ha7) begin
      errors++; $display("FAIL video_bank got %h want a7", video_bank);
    end
    step(0, 1, 0, 5'h0c, 8'h11, 0);
    checks++;
    if (video_bank !== 8'ha7) begin
      errors++; $display("FAIL video_bank_no_cen got %h want a7", video_bank);
    end
  endtask

  task automatic test_sound();
    int high;
    do_reset();
    step(1, 1, 0, 5'h14, 8'h3c, 0);
    step(1, 1, 0, 5'h18, 8'h00, 0);
    high = snd_irq ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 1, 5'h1f, 8'h00, 0);
      if (snd_irq) high++;
    end
    checks++;
    if (snd_latch !== 8'h3c) begin
      errors++; $display("FAIL snd_latch got %h want 3c", snd_latch);
    end
    checks++;
    if (high != IRQ_LEN) begin
      errors++; $display("FAIL irq_length got %0d ticks want %0d", high, IRQ_LEN);
    end
    step(1, 1, 0, 5'h18, 8'h00, 0);
    idle(3);
    step(0, 0, 1, 5'h1f, 8'h00, 1);
    checks++;
    if (snd_irq !== 1'b0) begin
      errors++; $display("FAIL irq_ack got %b want 0", snd_irq);
    end
    step(1, 1, 0, 5'h18, 8'h00, 0);
    idle(5);
    step(1, 1, 0, 5'h18, 8'h00, 1);
    checks++;
    if (snd_irq !== 1'b1) begin
      errors++; $display("FAIL irq_trig_vs_ack got %b want 1", snd_irq);
    end
    idle(7);
    checks++;
    if (snd_irq !== 1'b1) begin
      errors++; $display("FAIL irq_reload got %b want 1", snd_irq);
    end
    idle(1);
    checks++;
    if (snd_irq !== 1'b0) begin
      errors++; $display("FAIL irq_reload_end got %b want 0", snd_irq);
    end
  endtask

  task automatic test_reads();
    joystick1 = 6'b111110; dipsw_c = 4'h5;
    step(1, 1, 1, 5'h01, 8'h00, 0);
    checks++;
    if (io_dout !== 8'hfd) begin
      errors++; $display("FAIL read_joy1 got %h want fd", io_dout);
    end
    step(0, 1, 1, 5'h06, 8'h00, 0);
    checks++;
    if (io_dout !== 8'hf5) begin
      errors++; $display("FAIL read_dipsw_c got %h want f5", io_dout);
    end
    step(1, 0, 1, 5'h01, 8'h00, 0);
    checks++;
    if (io_dout !== 8'hf5) begin
      errors++; $display("FAIL read_hold got %h want f5", io_dout);
    end
    step(1, 1, 1, 5'h0c, 8'h00, 0);
    checks++;
    if (io_dout !== 8'hff) begin
      errors++; $display("FAIL read_other_window got %h want ff", io_dout);
    end
  endtask

  task automatic test_watchdog();
    int pulses, first;
    do_reset();
    pulses = 0; first = -1;
    for (int t = 1; t <= 3 * c_WD_PER + 5; t++) begin
      step(1, 0, 1, 5'h1f, 8'h00, 0);
      if (wdog_rst) begin
        pulses++;
        if (first < 0) first = t;
      end
    end
    checks++;
    if (pulses != 3 || first != c_WD_PER) begin
      errors++;
      $display("FAIL wdog_period got %0d pulses first at %0d want 3 first at %0d",
               pulses, first, c_WD_PER);
    end
    pulses = 0;
    for (int t = 1; t <= 60; t++) begin
      if (t % 10 == 0) step(1, 1, 0, 5'h1c, 8'h00, 0);
      else step(1, 0, 1, 5'h1f, 8'h00, 0);
      if (wdog_rst) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL wdog_kicked got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_coin();
    int high;
    do_reset();
    step(1, 1, 0, 5'h08, 8'h01, 0);
    high = coin_cnt[0] ? 1 : 0;
    step(1, 1, 0, 5'h08, 8'h00, 0);
    if (coin_cnt[0]) high++;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 5'h1f, 8'h00, 0);
      if (coin_cnt[0]) high++;
    end
    checks++;
    if (high != COIN_LEN) begin
      errors++; $display("FAIL coin_pulse got %0d ticks want %0d", high, COIN_LEN);
    end
    step(1, 1, 0, 5'h08, 8'h03, 0);
    step(1, 1, 0, 5'h18, 8'h00, 0);
    step(1, 1, 0, 5'h08, 8'h00, 0);
    do_reset();
    checks++;
    if (coin_cnt !== 2'b00 || snd_irq !== 1'b0) begin
      errors++; $display("FAIL coin_rst_mid got coin=%b irq=%b want 00 0", coin_cnt, snd_irq);
    end
  endtask

  task automatic test_random();
    logic [39:0] exp_v, got_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      start_button = 2'($urandom); coin_input = 2'($urandom); service = 1'($urandom);
      joystick1 = 6'($urandom); joystick2 = 6'($urandom);
      dipsw_a = 8'($urandom); dipsw_b = 8'($urandom); dipsw_c = 4'($urandom);
      step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 5'($urandom),
           8'($urandom), $urandom_range(0, 9) == 0);
      exp_v = exp_all();
      got_v = dut_all();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL random_step%0d got %h want %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_cen = 1'b0; io_cs = 1'b0; rnw = 1'b1; addr = '0; cpu_dout = '0;
    snd_ack = 1'b0; start_button = 2'b11; coin_input = 2'b11; service = 1'b1;
    joystick1 = 6'h3f; joystick2 = 6'h3f; dipsw_a = 8'hff; dipsw_b = 8'hff;
    dipsw_c = 4'hf;
    model_reset();
    test_reset();
    test_bank();
    test_sound();
    test_reads();
    test_watchdog();
    test_coin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
